comms_rx_gate: RTL and testbench
================================

// Module: comms_rx_gate
// PURPOSE
//  Receive-side stage directly downstream of the two-stage key-gated link.
//  Consumes the ciphertext byte stream and decrypts each byte with the receiver
//  key (data ^ key_out). Admits a byte only when the receiver key matches the
//  sender key, and buffers admitted bytes in a FIFO with a valid/ready output.
//  Locks out the receiver after repeated key mismatches until an authenticated unlock.
// PARAMETERS
//  WIDTH      8  data and key width in bits
//  DEPTH      4  FIFO depth in entries; power of 2, >= 2
//  MAX_FAILS  3  consecutive mismatches that force LOCKED; range 1..15
// PORTS
//  clk_bar     in   1            clock; all registers update on its rising edge
//  clr_bar     in   1            reset, asynchronous, active-low
//  in_valid    in   1            in_data is presented this cycle
//  in_data     in   WIDTH        ciphertext byte from upstream stage
//  key_in      in   WIDTH        sender key
//  key_out     in   WIDTH        receiver key
//  unlock      in   1            single-cycle unlock request
//  out_valid   out  1            out_data holds the FIFO head
//  out_data    out  WIDTH        decrypted byte at the FIFO head
//  out_ready   in   1            consumer accepts the head when out_valid=1
//  fifo_count  out  $clog2(DEPTH)+1  number of entries currently held
//  fail_count  out  4            consecutive mismatch count
//  locked      out  1            1 while in LOCKED
//  overflow    out  1            sticky; set when an admitted byte is dropped on full
// BEHAVIOUR
//  - Reset (clr_bar=0, takes effect immediately): FIFO emptied, out_valid=0,
//    out_data=0, fifo_count=0, fail_count=0, locked=0, overflow=0, state=OPEN.
//    Reset mid-transfer discards all buffered data.
//  - match = (key_out == key_in), evaluated combinationally each cycle.
//  - FSM states: OPEN, LOCKED. locked is a registered decode of LOCKED.
//  - OPEN, in_valid=1, match=1: push (in_data ^ key_out); fail_count <= 0.
//  - OPEN, in_valid=1, match=0: byte dropped; fail_count <= fail_count+1.
//    If the new count equals MAX_FAILS, go to LOCKED on the same edge.
//  - OPEN, in_valid=0: no change. unlock is ignored while in OPEN.
//  - LOCKED: in_valid is ignored; no push; fail_count holds.
//    unlock=1 with match=1: go to OPEN and clear fail_count (next edge).
//    unlock=1 with match=0: stay in LOCKED.
//  - The FIFO continues to drain while the block is LOCKED.
//  - FIFO is first-word-fall-through with registered storage.
//  - A push into an empty FIFO gives out_valid=1 on the next cycle, with
//    out_data equal to the pushed value (latency 1).
//  - Pop occurs when out_valid & out_ready. out_data is stable while
//    out_valid=1 and out_ready=0.
//  - Push while full and no pop: the byte is dropped and overflow <= 1.
//    overflow stays set until reset. fail_count is unaffected.
//  - Push while full with a pop in the same cycle: both occur; count unchanged.
//  - Push and pop on a non-empty, non-full FIFO: both occur; count unchanged.
//  - out_ready while empty: no effect.
//  - Read and write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
//    fifo_count never exceeds DEPTH.
// TESTING
//  1 Reset: clr_bar low mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
//  2 key_in=key_out=8'h2E, push 8'h05, out_ready=1 -> out_valid 1 cycle later, out_data=8'h2B.
//  3 key_out=8'h2F, key_in=8'h2E, 3 pushes -> fail_count 1,2,3; locked=1 after the 3rd; FIFO empty.
//  4 LOCKED: unlock with key_out=8'h2F -> stays locked; set key_out=8'h2E and unlock -> locked=0 next cycle,
//    fail_count=0, and a subsequent push of 8'h05 yields 8'h2B.
//  5 out_ready=0, 5 matched pushes of 8'h01..8'h05 with key 8'h00 -> fifo_count=4, overflow=1;
//    then raise out_ready -> out_data reads 8'h01..8'h04 in order.
//  6 FIFO full with a simultaneous push and pop -> fifo_count stays 4, overflow stays 0, order preserved.

Source files
------------

// File: rtl/comms_rx_gate.sv
// comms_rx_gate: receive-side gate behind the key-gated link.
// Decrypts each ciphertext byte with the receiver key, admits it only when the
// receiver key matches the sender key, buffers admitted bytes in a first-word-
// fall-through FIFO, and locks out after MAX_FAILS consecutive key mismatches
// until an unlock request arrives with matching keys.
//
// Output handshake (valid/ready): out_valid=1 means out_data holds the FIFO head.
// A transfer (pop) happens on a rising clk_bar edge where out_valid & out_ready
// are both 1. While out_valid=1 and out_ready=0, out_data holds steady.
// out_valid never depends on out_ready. out_ready while out_valid=0 has no effect.
// The input side has no backpressure: in_valid qualifies in_data for one cycle,
// and a byte that cannot be stored is dropped and flagged in sticky overflow.
module comms_rx_gate #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int MAX_FAILS = 3
) (
    input  logic                     clk_bar,
    input  logic                     clr_bar,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [WIDTH-1:0]         key_in,
    input  logic [WIDTH-1:0]         key_out,
    input  logic                     unlock,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [3:0]               fail_count,
    output logic                     locked,
    output logic                     overflow,
    output logic                     state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        OPEN   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        fail_q, fail_d;
    logic              locked_q;
    logic              overflow_q;
    logic              match;
    logic              push_req;
    logic              pop;
    logic              full;
    logic              do_push;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count_q;

    assign match     = (key_out == key_in);
    assign out_valid = (count_q != '0);
    assign full      = (count_q == CW'(DEPTH));
    assign pop       = out_valid & out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push   = push_req & (~full | pop);

    assign out_data   = out_valid ? mem[rd_ptr] : '0;
    assign fifo_count = count_q;
    assign fail_count = fail_q;
    assign locked     = locked_q;
    assign overflow   = overflow_q;
    assign state_dbg  = (state_q == LOCKED);

    // Next-state, mismatch counting and push request decode.
    always_comb begin
        state_d  = state_q;
        fail_d   = fail_q;
        push_req = 1'b0;
        case (state_q)
            OPEN: begin
                if (in_valid) begin
                    if (match) begin
                        push_req = 1'b1;
                        fail_d   = 4'd0;
                    end else begin
                        fail_d = fail_q + 4'd1;
                        if (fail_d == 4'(MAX_FAILS)) begin
                            state_d = LOCKED;
                        end
                    end
                end
            end
            LOCKED: begin
                if (unlock && match) begin
                    state_d = OPEN;
                    fail_d  = 4'd0;
                end
            end
            default: begin
                state_d = OPEN;
                fail_d  = 4'd0;
            end
        endcase
    end

    // State register, mismatch counter and registered locked decode.
    always_ff @(posedge clk_bar or negedge clr_bar) begin
        if (!clr_bar) begin
            state_q  <= OPEN;
            fail_q   <= 4'd0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            fail_q   <= fail_d;
            locked_q <= (state_d == LOCKED);
        end
    end

    // FIFO storage, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk_bar or negedge clr_bar) begin
        if (!clr_bar) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= in_data ^ key_out;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (!do_push && pop) begin
                count_q <= count_q - CW'(1);
            end
            if (push_req && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_comms_rx_gate.sv
// tb_comms_rx_gate: directed-vector bench for comms_rx_gate with hand-computed
// expected values. Inputs change 1 ns after a rising edge; outputs are
// sampled at that same point, well away from the next edge.
module tb_comms_rx_gate;

    logic        clk_bar;
    logic        clr_bar;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [7:0]  key_in;
    logic [7:0]  key_out;
    logic        unlock;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [2:0]  fifo_count;
    logic [3:0]  fail_count;
    logic        locked;
    logic        overflow;
    logic        state_dbg;

    int checks = 0;
    int errors = 0;

    comms_rx_gate #(.WIDTH(8), .DEPTH(4), .MAX_FAILS(3)) dut (
        .clk_bar    (clk_bar),
        .clr_bar    (clr_bar),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .key_in     (key_in),
        .key_out    (key_out),
        .unlock     (unlock),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .fail_count (fail_count),
        .locked     (locked),
        .overflow   (overflow),
        .state_dbg  (state_dbg)
    );

    // Clock and time guard.
    initial clk_bar = 1'b0;
    always #5 clk_bar = ~clk_bar;

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, want finish before 100000 ns");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_bar);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".out_valid"},  32'(out_valid),  32'd0);
        check({tag, ".out_data"},   32'(out_data),   32'd0);
        check({tag, ".fifo_count"}, 32'(fifo_count), 32'd0);
        check({tag, ".fail_count"}, 32'(fail_count), 32'd0);
        check({tag, ".locked"},     32'(locked),     32'd0);
        check({tag, ".overflow"},   32'(overflow),   32'd0);
    endtask

    task automatic push(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    logic [7:0] exp_q[$];

    initial begin
        clr_bar   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        key_in    = 8'h00;
        key_out   = 8'h00;
        unlock    = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        check_all_zero("reset");
        check("reset.state", 32'(state_dbg), 32'd0);
        clr_bar = 1'b1;
        step();

        // Matched push, latency 1, decrypted output.
        key_in    = 8'h2E;
        key_out   = 8'h2E;
        out_ready = 1'b1;
        check("t2.pre_valid", 32'(out_valid), 32'd0);
        push(8'h05);
        check("t2.out_valid", 32'(out_valid), 32'd1);
        check("t2.out_data",  32'(out_data),  32'h2B);
        check("t2.count",     32'(fifo_count), 32'd1);
        step();
        check("t2.drained",   32'(out_valid), 32'd0);

        // Three mismatches lock the receiver.
        key_out = 8'h2F;
        push(8'h11);
        check("t3.fail1",   32'(fail_count), 32'd1);
        check("t3.locked1", 32'(locked),     32'd0);
        push(8'h12);
        check("t3.fail2",   32'(fail_count), 32'd2);
        check("t3.locked2", 32'(locked),     32'd0);
        push(8'h13);
        check("t3.fail3",   32'(fail_count), 32'd3);
        check("t3.locked3", 32'(locked),     32'd1);
        check("t3.state",   32'(state_dbg),  32'd1);
        check("t3.count",   32'(fifo_count), 32'd0);

        // Unlock with wrong key stays locked.
        unlock = 1'b1;
        step();
        unlock = 1'b0;
        check("t4.bad_unlock.locked", 32'(locked),     32'd1);
        check("t4.bad_unlock.fail",   32'(fail_count), 32'd3);
        // Matching byte while locked is ignored.
        key_out = 8'h2E;
        push(8'h05);
        check("t4.locked_push.count", 32'(fifo_count), 32'd0);
        check("t4.locked_push.fail",  32'(fail_count), 32'd3);
        check("t4.locked_push.lock",  32'(locked),     32'd1);
        // Good unlock.
        unlock = 1'b1;
        step();
        unlock = 1'b0;
        check("t4.unlock.locked", 32'(locked),     32'd0);
        check("t4.unlock.fail",   32'(fail_count), 32'd0);
        push(8'h05);
        check("t4.push.valid", 32'(out_valid), 32'd1);
        check("t4.push.data",  32'(out_data),  32'h2B);
        step();
        check("t4.drained", 32'(fifo_count), 32'd0);

        // Fill past capacity with out_ready low.
        key_in    = 8'h00;
        key_out   = 8'h00;
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            push(8'(i));
        end
        check("t5.count",    32'(fifo_count), 32'd4);
        check("t5.overflow", 32'(overflow),   32'd1);
        check("t5.fail",     32'(fail_count), 32'd0);
        check("t5.hold",     32'(out_data),   32'h01);
        step();
        check("t5.stable",   32'(out_data),   32'h01);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("t5.drain%0d", i), 32'(out_data), 32'(i));
            step();
        end
        check("t5.empty",       32'(out_valid), 32'd0);
        check("t5.sticky_ovf",  32'(overflow),  32'd1);

        // Mid-cycle reset with buffered data and a nonzero fail count.
        out_ready = 1'b0;
        push(8'h33);
        push(8'h44);
        key_out = 8'h01;
        push(8'h55);
        check("rst.pre_count", 32'(fifo_count), 32'd2);
        check("rst.pre_fail",  32'(fail_count), 32'd1);
        #3;
        clr_bar = 1'b0;
        #1;
        check_all_zero("rst_mid");
        step();
        clr_bar = 1'b1;
        key_out = 8'h00;
        step();
        check_all_zero("rst_after");

        // Full FIFO with simultaneous push and pop.
        out_ready = 1'b0;
        exp_q = {};
        for (int i = 0; i < 4; i++) begin
            push(8'hA1 + 8'(i));
            exp_q.push_back(8'hA1 + 8'(i));
        end
        check("t6.full",     32'(fifo_count), 32'd4);
        check("t6.ovf_pre",  32'(overflow),   32'd0);
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(8'hA5);
        check("t6.count",    32'(fifo_count), 32'd4);
        check("t6.overflow", 32'(overflow),   32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t6.order%0d", i), 32'(out_data), 32'(exp_q[i]));
            step();
        end
        check("t6.empty", 32'(fifo_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
